// File: rtl/route_compute_unit.sv
// -----------------------------------------------------------------------------
// route_compute_unit
//
// Per-channel route computation stage for a wormhole router. Each channel
// decodes the flit type, looks up the head flit's destination in a routing
// table shared by all channels, and registers the flit together with its
// output-port request in a one-entry pipeline register. Body and tail flits
// reuse the route captured by their head.
//
// Optional feature macro: DEST_CHECK_EN
//   defined   : heads addressed to a node >= N raise route_err and the rest
//               of that packet is dropped (DROP state).
//   undefined : no range check; the destination field indexes the table as is.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   in_flit      CHANNELS*FLIT_W  input flits, channel c at [c*FLIT_W +: FLIT_W]
//   in_valid     CHANNELS         flit present
//   in_ready     CHANNELS         flit accepted (= !out_valid | out_ready)
//   out_flit     CHANNELS*FLIT_W  registered flits
//   out_request  CHANNELS*REQUEST_WIDTH  output-port request per channel
//   out_valid    CHANNELS         output register holds a flit
//   out_ready    CHANNELS         downstream accepts the held flit
//   cfg_we       routing-table write enable
//   cfg_addr     routing-table entry to write
//   cfg_data     routing-table write data
//   route_err    CHANNELS         one-cycle error pulse per channel
//
// Flit type (top two bits): 01 head, 00 body, 10 tail, 11 head+tail.
// -----------------------------------------------------------------------------
module route_compute_unit #(
  parameter int N             = 4,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 8,
  parameter int PhitPerFlit   = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int CHANNELS      = 2,
  localparam int FLIT_W = PhitPerFlit * DATA_WIDTH,
  localparam int DEST_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS*FLIT_W-1:0]         in_flit,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  output logic [CHANNELS*FLIT_W-1:0]         out_flit,
  output logic [CHANNELS*REQUEST_WIDTH-1:0]  out_request,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ready,
  input  logic                               cfg_we,
  input  logic [DEST_W-1:0]                  cfg_addr,
  input  logic [REQUEST_WIDTH-1:0]           cfg_data,
  output logic [CHANNELS-1:0]                route_err
);

  // INDEX only identifies the router instance; reject nonsense values early.
  if (INDEX < 0) begin : g_index_check
    $error("route_compute_unit: INDEX must be non-negative");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUTED = 2'd1;
`ifdef DEST_CHECK_EN
  localparam logic [1:0] DROP   = 2'd2;
`endif

  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  // ---------------------------------------------------------------------------
  // Shared routing table: one write port, one combinational read per channel.
  // A lookup in the same cycle as a write sees the pre-edge contents because
  // the write only lands on the clock edge.
  // ---------------------------------------------------------------------------
  logic [REQUEST_WIDTH-1:0] routeTable [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the table is a small flop array, not a RAM macro, so clearing it
      // on reset is both legal and required here.
      for (int i = 0; i < N; i++) begin
        routeTable[i] <= '0;
      end
    end else if (cfg_we && (int'(cfg_addr) < N)) begin
      routeTable[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel route FSM and output register
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [FLIT_W-1:0]        flit;
    logic [1:0]               flitType;
    logic [DEST_W-1:0]        dest;
    logic                     isHead;
    logic                     isTail;
    logic                     xfer;
    logic [REQUEST_WIDTH-1:0] lookup;

    logic [1:0]               state;
    logic [1:0]               stateNext;
    logic                     outValidQ;
    logic                     outValidNext;
    logic [FLIT_W-1:0]        outFlitQ;
    logic [REQUEST_WIDTH-1:0] outRequestQ;
    logic                     errQ;
    logic                     errNext;
    logic                     loadFlit;
    logic                     loadRoute;

    assign flit     = in_flit[c*FLIT_W +: FLIT_W];
    assign flitType = flit[FLIT_W-1 -: 2];
    assign dest     = flit[DEST_W-1:0];
    assign isHead   = flitType[0];           // 01 head, 11 head+tail
    assign isTail   = flitType[1];           // meaningful for heads: 11 closes the packet
    assign xfer     = in_valid[c] && in_ready[c];
    // Unpopulated entries (non power-of-two N) read as "no route".
    assign lookup   = (int'(dest) < N) ? routeTable[dest] : '0;

    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      stateNext    = state;
      outValidNext = outValidQ && !out_ready[c];
      errNext      = 1'b0;
      loadFlit     = 1'b0;
      loadRoute    = 1'b0;

      if (xfer) begin
        // A transfer either refills the register or (error/drop) leaves it empty.
        outValidNext = 1'b0;
`ifdef DEST_CHECK_EN
        if (state == DROP) begin
          if (flitType == TYPE_TAIL) begin
            stateNext = IDLE;
          end
        end else
`endif
        if (isHead) begin
          // A head while a packet is still open is flagged but still re-routes.
          errNext = (state == ROUTED);
`ifdef DEST_CHECK_EN
          if (int'(dest) >= N) begin
            errNext   = 1'b1;
            stateNext = isTail ? IDLE : DROP;
          end else
`endif
          begin
            loadFlit     = 1'b1;
            loadRoute    = 1'b1;
            outValidNext = 1'b1;
            stateNext    = isTail ? IDLE : ROUTED;
          end
        end else if (state == ROUTED) begin
          loadFlit     = 1'b1;
          outValidNext = 1'b1;
          if (flitType == TYPE_TAIL) begin
            stateNext = IDLE;
          end
        end else begin
          // Body/tail with no open packet: swallow it and report.
          errNext = (flitType == TYPE_BODY) || (flitType == TYPE_TAIL);
        end
      end
    end

    // outRequestQ doubles as the held route: only heads reload it, so body
    // and tail flits automatically carry their head's request.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        state       <= IDLE;
        outValidQ   <= 1'b0;
        outFlitQ    <= '0;
        outRequestQ <= '0;
        errQ        <= 1'b0;
      end else begin
        state     <= stateNext;
        outValidQ <= outValidNext;
        errQ      <= errNext;
        if (loadFlit) begin
          outFlitQ <= flit;
        end
        if (loadRoute) begin
          outRequestQ <= lookup;
        end
      end
    end

    assign in_ready[c]                                    = !outValidQ || out_ready[c];
    assign out_valid[c]                                   = outValidQ;
    assign out_flit[c*FLIT_W +: FLIT_W]                   = outFlitQ;
    assign out_request[c*REQUEST_WIDTH +: REQUEST_WIDTH]  = outRequestQ;
    assign route_err[c]                                   = errQ;
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// -----------------------------------------------------------------------------
// tb_route_compute_unit
//
// Scoreboard bench for route_compute_unit (N=4, CHANNELS=2, 16-bit flits).
// A packet-level reference model runs on each rising edge, decides whether the
// channel accepted a flit, and queues the expected output and error pulse.
// A monitor on the falling edge compares the DUT outputs against the queue
// front and pops it when the downstream accepts. Stimulus is driven 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_route_compute_unit;

  localparam int N  = 4;
  localparam int CH = 2;
  localparam int FW = 16;
  localparam int RW = 2;
  localparam int DW = 2;

  typedef enum int {M_IDLE, M_ROUTED} model_state_e;
  typedef struct packed {
    logic [FW-1:0] flit;
    logic [RW-1:0] req;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [CH*FW-1:0]    in_flit = '0;
  logic [CH-1:0]       in_valid = '0;
  logic [CH-1:0]       in_ready;
  logic [CH*FW-1:0]    out_flit;
  logic [CH*RW-1:0]    out_request;
  logic [CH-1:0]       out_valid;
  logic [CH-1:0]       out_ready = '1;
  logic                cfg_we = 1'b0;
  logic [DW-1:0]       cfg_addr = '0;
  logic [RW-1:0]       cfg_data = '0;
  logic [CH-1:0]       route_err;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  exp_t          expQ [CH][$];
  model_state_e  mState [CH];
  bit            mValid [CH];
  logic [RW-1:0] mRoute [CH];
  bit            expErr [CH];
  logic [RW-1:0] tbl [N];

  logic [FW-1:0] mFlit;
  logic [1:0]    mType;
  bit            mAccept;
  bit            mEmit;
  bit            mErr;
  exp_t          front;

  route_compute_unit #(
    .N(N), .INDEX(1), .DATA_WIDTH(8), .PhitPerFlit(2),
    .REQUEST_WIDTH(RW), .CHANNELS(CH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_request(out_request), .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .route_err(route_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: packet rules at flit granularity, evaluated at the edge.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        mFlit   = in_flit[c*FW +: FW];
        mType   = mFlit[FW-1 -: 2];
        mAccept = in_valid[c] && (!mValid[c] || out_ready[c]);
        mEmit   = 1'b0;
        mErr    = 1'b0;
        if (mAccept) begin
          if (mType == 2'b01 || mType == 2'b11) begin
            mErr      = (mState[c] == M_ROUTED);
            mRoute[c] = tbl[mFlit[DW-1:0]];           // table before this edge's write
            mEmit     = 1'b1;
            mState[c] = (mType == 2'b11) ? M_IDLE : M_ROUTED;
          end else if (mState[c] == M_ROUTED) begin
            mEmit = 1'b1;
            if (mType == 2'b10) mState[c] = M_IDLE;
          end else begin
            mErr = 1'b1;
          end
        end
        if (mEmit) expQ[c].push_back('{flit: mFlit, req: mRoute[c]});
        mValid[c] = mEmit || (mValid[c] && !out_ready[c]);
        expErr[c] = mErr;
      end
      if (cfg_we) tbl[cfg_addr] = cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare presented outputs with the scoreboard front.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("ch%0d out_valid", c), 32'(out_valid[c]), 32'(expQ[c].size() != 0));
        check($sformatf("ch%0d in_ready", c), 32'(in_ready[c]),
              32'((expQ[c].size() == 0) || out_ready[c]));
        check($sformatf("ch%0d route_err", c), 32'(route_err[c]), 32'(expErr[c]));
        if (out_valid[c] && expQ[c].size() != 0) begin
          front = expQ[c][0];
          check($sformatf("ch%0d out_flit", c), 32'(out_flit[c*FW +: FW]), 32'(front.flit));
          check($sformatf("ch%0d out_request", c), 32'(out_request[c*RW +: RW]), 32'(front.req));
          if (out_ready[c]) void'(expQ[c].pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlit(input int c, input logic [FW-1:0] f);
    in_valid[c]          = 1'b1;
    in_flit[c*FW +: FW]  = f;
  endtask

  task automatic clearInputs();
    in_valid = '0;
    cfg_we   = 1'b0;
  endtask

  task automatic cfgWrite(input logic [DW-1:0] a, input logic [RW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after
  // the rising edge.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_flit", out_flit, 32'h0);
    check("reset out_request", 32'(out_request), 32'h0);
    check("reset route_err", 32'(route_err), 32'h0);
    for (int c = 0; c < CH; c++) begin
      expQ[c].delete();
      mValid[c] = 1'b0;
      mState[c] = M_IDLE;
      mRoute[c] = '0;
      expErr[c] = 1'b0;
    end
    for (int i = 0; i < N; i++) tbl[i] = '0;
    clearInputs();
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      mState[c] = M_IDLE; mValid[c] = 1'b0; mRoute[c] = '0; expErr[c] = 1'b0;
    end
    for (int i = 0; i < N; i++) tbl[i] = '0;

    doReset();

    // Three-flit packet to node 3, full throughput.
    cfgWrite(2'd3, 2'b10);
    setFlit(0, 16'h4003); step();
    check("pkt head valid", 32'(out_valid[0]), 32'h1);
    check("pkt head req", 32'(out_request[1:0]), 32'h2);
    setFlit(0, 16'h0011); step();
    check("pkt body flit", 32'(out_flit[15:0]), 32'h0011);
    check("pkt body req", 32'(out_request[1:0]), 32'h2);
    setFlit(0, 16'h8022); step();
    check("pkt tail flit", 32'(out_flit[15:0]), 32'h8022);
    check("pkt tail req", 32'(out_request[1:0]), 32'h2);
    clearInputs(); step();
    check("pkt drained", 32'(out_valid[0]), 32'h0);

    // Backpressure: head held while downstream stalls.
    out_ready[0] = 1'b0;
    setFlit(0, 16'h4001); step();
    check("stall head err", 32'(route_err[0]), 32'h0);
    setFlit(0, 16'h8000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall in_ready", 32'(in_ready[0]), 32'h0);
      check("stall flit held", 32'(out_flit[15:0]), 32'h4001);
    end
    out_ready[0] = 1'b1; step();
    check("stall release flit", 32'(out_flit[15:0]), 32'h8000);
    clearInputs(); step();
    check("stall drained", 32'(out_valid[0]), 32'h0);

    // Same-cycle table write and lookup uses the old entry.
    cfgWrite(2'd2, 2'b01);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 2'b11;
    setFlit(1, 16'h4002); step();
    cfg_we = 1'b0;
    check("wr/rd same cycle", 32'(out_request[3:2]), 32'h1);
    setFlit(1, 16'h8000); step();
    setFlit(1, 16'hC002); step();
    check("wr/rd new value", 32'(out_request[3:2]), 32'h3);
    check("wr/rd no err", 32'(route_err[1]), 32'h0);

    // Body with no open packet.
    setFlit(1, 16'h0055); step();
    check("orphan body err", 32'(route_err[1]), 32'h1);
    check("orphan body no out", 32'(out_valid[1]), 32'h0);
    clearInputs(); step();
    check("orphan err pulse", 32'(route_err[1]), 32'h0);

    // Both channels in one cycle.
    cfgWrite(2'd0, 2'b01);
    setFlit(0, 16'hC000); setFlit(1, 16'h4003); step();
    check("dual valid", 32'(out_valid), 32'h3);
    check("dual req ch0", 32'(out_request[1:0]), 32'h1);
    check("dual req ch1", 32'(out_request[3:2]), 32'h2);
    setFlit(0, 16'h0001); setFlit(1, 16'h0077); step();
    check("dual states err", 32'(route_err), 32'h1);
    check("dual states valid", 32'(out_valid), 32'h2);
    clearInputs();

    // Reset in the middle of a packet.
    out_ready[0] = 1'b0;
    setFlit(0, 16'h4003); step();
    check("pre-reset valid", 32'(out_valid[0]), 32'h1);
    clearInputs();
    doReset();
    setFlit(0, 16'h0011); step();
    check("post-reset body err", 32'(route_err[0]), 32'h1);
    check("post-reset body no out", 32'(out_valid[0]), 32'h0);
    setFlit(0, 16'h4003); step();
    check("post-reset table zero", 32'(out_request[1:0]), 32'h0);
    clearInputs(); step();

    // Randomized traffic, table writes and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c]         = ($urandom_range(0, 9) < 7);
        in_flit[c*FW +: FW] = {2'($urandom_range(0, 3)), 14'($urandom)};
        out_ready[c]        = ($urandom_range(0, 9) < 7);
      end
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_addr = 2'($urandom);
      cfg_data = 2'($urandom);
      if (i == 1500) doReset();
      else step();
    end

    clearInputs();
    out_ready = '1;
    repeat (4) step();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ch%0d scoreboard drained", c), 32'(expQ[c].size()), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
